// File: rtl/prince_cms_pkg.sv
// -----------------------------------------------------------------------------
// prince_cms_pkg
// Shared constants, share-vector typedefs and index helpers for the
// first-order CMS-masked PRINCE S-box datapath.
//   PRINCE_SBOX_BITS : S-box output bits
//   CMS_IN_SHARES    : expanded shares per output bit (component-function side)
//   CMS_OUT_SHARES   : compressed shares per output bit (round-layer side)
// Share vectors are flat: bit b, share s lives at b*<shares>+s.
// -----------------------------------------------------------------------------
package prince_cms_pkg;

    localparam int PRINCE_SBOX_BITS = 4;
    localparam int CMS_IN_SHARES    = 8;
    localparam int CMS_OUT_SHARES   = 2;

    typedef logic [PRINCE_SBOX_BITS*CMS_IN_SHARES-1:0]  cms_exp_vec_t;
    typedef logic [PRINCE_SBOX_BITS*CMS_OUT_SHARES-1:0] cms_cmp_vec_t;

    // Flat position of share s of bit b in a vector with n shares per bit.
    function automatic int share_idx(input int b, input int s, input int n);
        return b * n + s;
    endfunction

    // Ring neighbour feeding share s: (s-1) mod n.
    function automatic int ring_prev(input int s, input int n);
        return (s + n - 1) % n;
    endfunction

endpackage

// File: rtl/cms_ring_refresh.sv
// -----------------------------------------------------------------------------
// cms_ring_refresh
// Purely combinational ring refresh for one S-box output bit:
//   refreshed[s] = share[s] ^ rnd[s] ^ rnd[(s-1) mod N]
// Each rnd bit enters exactly two neighbouring shares, so the XOR of all
// shares is preserved while every share is re-masked.
// Build option: CMS_RING_REFRESH_EN. When undefined the block is a plain
// pass-through (functional/debug build, not side-channel secure) and rnd
// is ignored.
// Ports:
//   share     in  N  expanded shares of one bit
//   rnd       in  N  fresh randomness for this bit
//   refreshed out N  re-masked shares
// -----------------------------------------------------------------------------
module cms_ring_refresh
    import prince_cms_pkg::*;
#(
    parameter int N = CMS_IN_SHARES
) (
    input  logic [N-1:0] share,
    input  logic [N-1:0] rnd,
    output logic [N-1:0] refreshed
);

`ifdef CMS_RING_REFRESH_EN
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_share
            assign refreshed[gi] = share[gi] ^ rnd[gi] ^ rnd[ring_prev(gi, N)];
        end
    endgenerate
`else
    assign refreshed = share;

    logic unused_rnd;
    assign unused_rnd = ^rnd;
`endif

endmodule

// File: rtl/prince_sbox_cms_compress.sv
// -----------------------------------------------------------------------------
// prince_sbox_cms_compress
// Output stage of the CMS-masked PRINCE S-box. Expanded shares are ring
// refreshed and registered (R1, the non-completeness glitch barrier), then
// each bit is compressed to NUM_OUT_SHARES shares by registered XOR trees
// (R2). Both stages form a 2-deep elastic valid/ready pipeline.
// Build option: CMS_RING_REFRESH_EN enables the ring refresh and makes
// rnd_valid_i part of the accept condition; otherwise shares pass unmasked
// and rnd_i / rnd_valid_i are ignored.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   shares_i     expanded shares, bit b share s at b*NUM_IN_SHARES+s
//   valid_i      shares_i valid
//   ready_o      stage can accept shares_i
//   rnd_i        fresh randomness, same indexing as shares_i
//   rnd_valid_i  rnd_i valid
//   shares_o     compressed shares, bit b share k at b*NUM_OUT_SHARES+k
//   valid_o      shares_o valid
//   ready_i      consumer accepts shares_o
// -----------------------------------------------------------------------------
module prince_sbox_cms_compress
    import prince_cms_pkg::*;
#(
    parameter int NUM_IN_SHARES  = CMS_IN_SHARES,
    parameter int NUM_OUT_SHARES = CMS_OUT_SHARES,
    parameter int NUM_BITS       = PRINCE_SBOX_BITS
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_BITS*NUM_IN_SHARES-1:0]   shares_i,
    input  logic                                valid_i,
    output logic                                ready_o,
    input  logic [NUM_BITS*NUM_IN_SHARES-1:0]   rnd_i,
    input  logic                                rnd_valid_i,
    output logic [NUM_BITS*NUM_OUT_SHARES-1:0]  shares_o,
    output logic                                valid_o,
    input  logic                                ready_i
);

    localparam int GRP = NUM_IN_SHARES / NUM_OUT_SHARES;
    localparam int IW  = NUM_BITS * NUM_IN_SHARES;
    localparam int OW  = NUM_BITS * NUM_OUT_SHARES;

    logic [IW-1:0] r1_reg;
    logic [IW-1:0] r1_next;
    logic          v1_reg;
    logic [OW-1:0] r2_reg;
    logic [OW-1:0] r2_next;
    logic          vo_reg;

    logic r2_load;
    logic r1_load;
    logic accept;

    // R2 drains or is empty; R1 can then move forward in the same cycle.
    assign r2_load = !vo_reg || ready_i;
    assign r1_load = !v1_reg || r2_load;
    assign ready_o = r1_load;

`ifdef CMS_RING_REFRESH_EN
    // Shares and randomness are consumed together, so rnd is never reused.
    assign accept = valid_i && rnd_valid_i && ready_o;
`else
    assign accept = valid_i && ready_o;

    logic unused_rnd_valid;
    assign unused_rnd_valid = rnd_valid_i;
`endif

    genvar gi, gk;
    generate
        for (gi = 0; gi < NUM_BITS; gi++) begin : g_bit
            cms_ring_refresh #(
                .N(NUM_IN_SHARES)
            ) u_refresh (
                .share     (shares_i[share_idx(gi, 0, NUM_IN_SHARES) +: NUM_IN_SHARES]),
                .rnd       (rnd_i[share_idx(gi, 0, NUM_IN_SHARES) +: NUM_IN_SHARES]),
                .refreshed (r1_next[share_idx(gi, 0, NUM_IN_SHARES) +: NUM_IN_SHARES])
            );

            // Output share k folds the k-th contiguous group of R1 shares;
            // only registered values feed this tree.
            for (gk = 0; gk < NUM_OUT_SHARES; gk++) begin : g_out
                assign r2_next[share_idx(gi, gk, NUM_OUT_SHARES)] =
                    ^r1_reg[share_idx(gi, gk * GRP, NUM_IN_SHARES) +: GRP];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_reg <= 1'b0;
            r1_reg <= '0;
            vo_reg <= 1'b0;
            r2_reg <= '0;
        end else begin
            if (r1_load) begin
                v1_reg <= accept;
            end
            if (accept) begin
                r1_reg <= r1_next;
            end
            if (r2_load) begin
                vo_reg <= v1_reg;
                if (v1_reg) begin
                    r2_reg <= r2_next;
                end
            end
        end
    end

    assign shares_o = r2_reg;
    assign valid_o  = vo_reg;

endmodule

// File: tb/tb_prince_sbox_cms_compress.sv
// -----------------------------------------------------------------------------
// tb_prince_sbox_cms_compress
// Self-checking bench for prince_sbox_cms_compress. Accepted inputs push
// their expected compressed shares into a queue; every output transfer pops
// and compares. Directed sequences cover latency, streaming, back-pressure,
// missing randomness and mid-flight reset. Follows CMS_RING_REFRESH_EN.
// -----------------------------------------------------------------------------
module tb_prince_sbox_cms_compress;
    import prince_cms_pkg::*;

`ifdef CMS_RING_REFRESH_EN
    localparam bit REFRESH_EN = 1'b1;
`else
    localparam bit REFRESH_EN = 1'b0;
`endif

    logic         clk;
    logic         rst;
    cms_exp_vec_t shares_i;
    logic         valid_i;
    logic         ready_o;
    cms_exp_vec_t rnd_i;
    logic         rnd_valid_i;
    cms_cmp_vec_t shares_o;
    logic         valid_o;
    logic         ready_i;

    prince_sbox_cms_compress dut (
        .clk         (clk),
        .rst         (rst),
        .shares_i    (shares_i),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .rnd_i       (rnd_i),
        .rnd_valid_i (rnd_valid_i),
        .shares_o    (shares_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] out;
        logic [3:0] nib;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   errors   = 0;
    int   xfer_cnt = 0;
    int   run_len  = 0;
    int   max_run  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: ring refresh (if built in) then group-XOR compression.
    function automatic logic [7:0] model(input logic [31:0] sh, input logic [31:0] rn);
        logic [7:0] o;
        logic       r;
        o = '0;
        for (int b = 0; b < 4; b++) begin
            for (int s = 0; s < 8; s++) begin
                r = sh[b*8+s];
                if (REFRESH_EN) r = r ^ rn[b*8+s] ^ rn[b*8+((s+7)%8)];
                o[b*2 + s/4] = o[b*2 + s/4] ^ r;
            end
        end
        return o;
    endfunction

    function automatic logic [3:0] share_xor(input logic [31:0] sh);
        logic [3:0] n;
        for (int b = 0; b < 4; b++) n[b] = ^sh[b*8 +: 8];
        return n;
    endfunction

    function automatic logic [3:0] out_nib(input logic [7:0] v, input int k);
        logic [3:0] n;
        for (int b = 0; b < 4; b++) n[b] = v[b*2+k];
        return n;
    endfunction

    // Random share set whose per-bit XOR equals nib.
    function automatic logic [31:0] mask_nib(input logic [3:0] nib, input logic [31:0] x);
        logic [31:0] v;
        v = x;
        for (int b = 0; b < 4; b++) v[b*8] = nib[b] ^ (^v[b*8+1 +: 7]);
        return v;
    endfunction

    // Scoreboard: push on accept, pop/compare on output transfer.
    always @(negedge clk) begin
        if (rst) begin
            sb_q.delete();
            run_len = 0;
        end else begin
            if (valid_o) begin
                run_len++;
                if (run_len > max_run) max_run = run_len;
            end else begin
                run_len = 0;
            end
            if (valid_o && ready_i) begin
                xfer_cnt++;
                if (sb_q.size() == 0) begin
                    check("sb_underflow", sb_q.size(), 1);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    $display("txn out shares=0x%02h xor=0x%0h exp_shares=0x%02h exp_xor=0x%0h",
                             shares_o, out_nib(shares_o, 0) ^ out_nib(shares_o, 1), e.out, e.nib);
                    check("sb_data", shares_o, e.out);
                    check("sb_xor", out_nib(shares_o, 0) ^ out_nib(shares_o, 1), e.nib);
                end
            end
            if (valid_i && ready_o && (rnd_valid_i || !REFRESH_EN)) begin
                exp_t e;
                e.out = model(shares_i, rnd_i);
                e.nib = share_xor(shares_i);
                sb_q.push_back(e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] sh_b;
        logic [7:0]  exp_a;
        int          x0;

        rst = 1'b1; valid_i = 0; rnd_valid_i = 0; ready_i = 0;
        shares_i = '0; rnd_i = '0;
        step();
        check("rst_ready_o", ready_o, 1);
        step();
        check("rst_valid_o", valid_o, 0);
        check("rst_shares_o", shares_o, 0);
        check("rst_ready_o2", ready_o, 1);
        rst = 1'b0;
        ready_i = 1'b1;
        step();

        // Nibble 0xB with share0 of each set bit, rnd only in share 3.
        sh_b = '0;
        for (int b = 0; b < 4; b++) sh_b[b*8] = (b != 2);
        shares_i = sh_b; rnd_i = 32'h0808_0808; valid_i = 1; rnd_valid_i = 1;
        step();
        valid_i = 0; rnd_valid_i = 0;
        check("lat_edge1_valid", valid_o, 0);
        step();
        check("lat_edge2_valid", valid_o, 1);
        check("b_out0", out_nib(shares_o, 0), REFRESH_EN ? 32'h4 : 32'hB);
        check("b_out1", out_nib(shares_o, 1), REFRESH_EN ? 32'hF : 32'h0);
        step(); step();

        // Back-to-back 0x0..0xF stream.
        max_run = 0;
        x0 = xfer_cnt;
        for (int i = 0; i < 16; i++) begin
            shares_i = mask_nib(4'(i), $urandom);
            rnd_i = $urandom; valid_i = 1; rnd_valid_i = 1;
            @(negedge clk);
            check("stream_ready_o", ready_o, 1);
            @(posedge clk); #1;
        end
        valid_i = 0; rnd_valid_i = 0;
        repeat (4) step();
        check("stream_count", xfer_cnt - x0, 16);
        check("stream_run", max_run, 16);

        // Back-pressure: two accepts then full.
        ready_i = 0;
        x0 = xfer_cnt;
        shares_i = mask_nib(4'h6, $urandom); rnd_i = $urandom;
        exp_a = model(shares_i, rnd_i);
        valid_i = 1; rnd_valid_i = 1;
        step();
        shares_i = mask_nib(4'h9, $urandom); rnd_i = $urandom;
        step();
        shares_i = mask_nib(4'h3, $urandom); rnd_i = $urandom;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("full_ready_o", ready_o, 0);
            check("full_hold", shares_o, exp_a);
            @(posedge clk); #1;
        end
        valid_i = 0; rnd_valid_i = 0;
        ready_i = 1;
        repeat (4) step();
        check("stall_count", xfer_cnt - x0, 2);

        // Randomness arrives late.
        x0 = xfer_cnt;
        shares_i = mask_nib(4'hA, $urandom); rnd_i = $urandom;
        valid_i = 1; rnd_valid_i = 0;
        repeat (3) begin
            @(negedge clk);
            check("norng_ready_o", ready_o, 1);
            @(posedge clk); #1;
        end
        rnd_valid_i = 1;
        step();
        valid_i = 0; rnd_valid_i = 0;
        check("norng_edge1_valid", valid_o, REFRESH_EN ? 0 : 1);
        step();
        check("norng_edge2_valid", valid_o, 1);
        repeat (4) step();
        check("norng_count", xfer_cnt - x0, REFRESH_EN ? 1 : 4);

        // Reset with both stages full.
        ready_i = 0;
        shares_i = mask_nib(4'h5, $urandom); rnd_i = $urandom;
        valid_i = 1; rnd_valid_i = 1;
        step(); step();
        valid_i = 0; rnd_valid_i = 0;
        check("pre_rst_ready_o", ready_o, 0);
        rst = 1;
        step();
        check("mid_rst_valid_o", valid_o, 0);
        check("mid_rst_shares_o", shares_o, 0);
        check("mid_rst_ready_o", ready_o, 1);
        rst = 0; ready_i = 1;
        x0 = xfer_cnt;
        repeat (5) step();
        check("post_rst_count", xfer_cnt - x0, 0);
        check("sb_drain", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
